// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipeline_stall_ctrl_pkg: shared CPU definitions for the pipeline stall controller
package pipeline_stall_ctrl_pkg;
    localparam int CNT_W = 32;
    typedef enum logic {RUN = 1'b0, KILL = 1'b1} state_e;
endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if: hazard inputs and pipeline register controls of the stall controller
interface pipeline_stall_ctrl_if;
    logic lu_haz_sig;
    logic branch_taken;
    logic imem_busy;
    logic dmem_busy;
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_bubble;
    logic [pipeline_stall_ctrl_pkg::CNT_W-1:0] stall_cnt;
    logic [pipeline_stall_ctrl_pkg::CNT_W-1:0] flush_cnt;
    modport master (
        output lu_haz_sig, branch_taken, imem_busy, dmem_busy,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble,
        input  stall_cnt, flush_cnt
    );
    modport slave (
        input  lu_haz_sig, branch_taken, imem_busy, dmem_busy,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// sat_counter: event counter with sync active-low clear that sticks at all-ones
module sat_counter
    import pipeline_stall_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (inc && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign cnt = cnt_q;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: five-stage stall/flush controller with a wrong-path fetch kill state
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_stall_ctrl_if.slave  bus
);
    state_e     state_q, state_d;
    logic [4:0] en;
    logic       flush, bubble, flush_evt;
    always_comb begin
        state_d   = state_q;
        en        = 5'b11111;
        flush     = 1'b0;
        bubble    = 1'b0;
        flush_evt = 1'b0;
        if (!rst_n) begin
            state_d = RUN;
            en      = 5'b00000;
            flush   = 1'b1;
            bubble  = 1'b1;
        end else if (bus.dmem_busy) begin
            en = 5'b00000;
        end else if (state_q == KILL) begin
            // wrong-path word is squashed; the ID/EX side only carries bubbles here
            en    = 5'b01111;
            flush = 1'b1;
            state_d = bus.imem_busy ? KILL : RUN;
        end else if (bus.branch_taken) begin
            flush     = 1'b1;
            bubble    = 1'b1;
            flush_evt = 1'b1;
            state_d   = bus.imem_busy ? KILL : RUN;
        end else if (bus.lu_haz_sig) begin
            en     = 5'b00111;
            bubble = 1'b1;
        end else if (bus.imem_busy) begin
            en    = 5'b01111;
            flush = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end
    assign bus.pc_en        = en[4];
    assign bus.if_id_en     = en[3];
    assign bus.id_ex_en     = en[2];
    assign bus.ex_mem_en    = en[1];
    assign bus.mem_wb_en    = en[0];
    assign bus.if_id_flush  = flush;
    assign bus.id_ex_bubble = bubble;
    sat_counter u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc(~en[4]),   .cnt(bus.stall_cnt));
    sat_counter u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc(flush_evt), .cnt(bus.flush_cnt));
endmodule
